// File: rtl/note_detector.sv
// note_detector
//   Measures the edge-to-edge interval (half-period) of a square-wave tone and
//   classifies it as one of the eight piano notes C4..C5. A note is reported
//   only after two consecutive classified half-periods agree.
//
//   Parameters
//     TOL        match window (+/- cycles) around each nominal half-period
//     TIMEOUT    cnt value at which a missing edge drops the lock (<= 2^19-1)
//     NOM_SHIFT  right-shift applied to the 100 MHz nominal table; 0 gives the
//                real C4..C5 half-periods, larger values track the same notes
//                scaled up in frequency by 2^NOM_SHIFT
//
//   Ports
//     CLK          system clock
//     RESET        synchronous, active-high reset
//     TONE_IN      asynchronous square-wave tone
//     NOTE         0 = none, 1..8 = C4, D, E, F, G, A, B, C5
//     NOTE_VALID   high while locked on NOTE
//     NOTE_CHANGE  one-cycle pulse when a lock is (re)acquired
//     HALF_PERIOD  most recent captured edge-to-edge interval, saturating
module note_detector #(
  parameter int unsigned TOL       = 1024,
  parameter int unsigned TIMEOUT   = 262143,
  parameter int unsigned NOM_SHIFT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TONE_IN,
  output logic [3:0]  NOTE,
  output logic        NOTE_VALID,
  output logic        NOTE_CHANGE,
  output logic [18:0] HALF_PERIOD
);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_e;

  localparam logic [18:0] TMO = 19'(TIMEOUT);

  // Nominal half-periods at 100 MHz, index 0 = C4 ... 7 = C5.
  localparam int unsigned NOM_FULL [8] = '{191110, 170266, 151686, 143173,
                                           127552, 113637, 101215, 95603};

  // Returns 1..8 for the note whose window contains hp, else 0. Windows never
  // overlap for legal TOL, so at most one index matches.
  function automatic logic [3:0] classify(input logic [18:0] hp);
    logic [31:0] v;
    logic [31:0] nom;
    classify = '0;
    v = {13'd0, hp};
    for (int i = 0; i < 8; i++) begin
      nom = NOM_FULL[i] >> NOM_SHIFT;
      if ((v + TOL >= nom) && (v <= nom + TOL)) classify = 4'(i + 1);
    end
  endfunction

  // sync_q[0], sync_q[1]: two-flop synchronizer; sync_q[2]: history flop.
  logic [2:0]  sync_q, sync_d;
  logic [18:0] cnt_q, cnt_d;
  logic [18:0] hp_q, hp_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  note_q, note_d;
  logic        valid_q, valid_d;
  logic        chg_q, chg_d;
  state_e      state_q, state_d;

  logic        tone_edge;
  logic [3:0]  cls;

  assign tone_edge = sync_q[2] ^ sync_q[1];
  assign cls       = classify(cnt_q);

  always_comb begin
    sync_d = {sync_q[1:0], TONE_IN};
    // cnt counts cycles since the last edge pulse; loading 1 makes the value
    // seen on the next edge equal the interval. It never exceeds TMO, so the
    // captured half-period saturates rather than wraps.
    if (tone_edge)         cnt_d = 19'd1;
    else if (cnt_q == TMO) cnt_d = cnt_q;
    else                   cnt_d = cnt_q + 19'd1;
    hp_d = tone_edge ? cnt_q : hp_q;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    note_d  = note_q;
    valid_d = valid_q;
    chg_d   = 1'b0;
    if (tone_edge) begin
      // An edge always beats a coincident timeout.
      unique case (state_q)
        IDLE:  state_d = ARMED;   // first interval is unknown, not classified
        ARMED: if (cls != '0) begin
          cand_d  = cls;
          state_d = TRACK;
        end
        TRACK: begin
          if (cls == '0) begin
            state_d = ARMED;
          end else if (cls == cand_q) begin
            state_d = LOCKED;
            note_d  = cls;
            valid_d = 1'b1;
            chg_d   = 1'b1;
          end else begin
            cand_d = cls;
          end
        end
        LOCKED: begin
          // Any mismatch drops the lock silently; the pulse comes on relock.
          if (cls == '0) begin
            state_d = ARMED;
            note_d  = '0;
            valid_d = 1'b0;
          end else if (cls != cand_q) begin
            state_d = TRACK;
            cand_d  = cls;
            note_d  = '0;
            valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == TMO) begin
      state_d = IDLE;
      cand_d  = '0;
      note_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      hp_q    <= '0;
      cand_q  <= '0;
      note_q  <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      cand_q  <= cand_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      state_q <= state_d;
    end
  end

  assign NOTE        = note_q;
  assign NOTE_VALID  = valid_q;
  assign NOTE_CHANGE = chg_q;
  assign HALF_PERIOD = hp_q;

endmodule

// File: tb/tb_note_detector.sv
// Testbench for note_detector. The note table is scaled down by 2^8 so that
// many half-periods fit in a short run; TOL and TIMEOUT are scaled to match.
// Directed table of intervals with hand-derived expectations, then random
// intervals checked against an interval-history model of the detector.
module tb_note_detector;

  localparam int TB_TOL   = 8;
  localparam int TB_TMO   = 1023;
  localparam int TB_SHIFT = 8;
  localparam int NOM_SPEC [8] = '{191110, 170266, 151686, 143173,
                                  127552, 113637, 101215, 95603};

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        TONE_IN = 1'b0;
  logic [3:0]  NOTE;
  logic        NOTE_VALID;
  logic        NOTE_CHANGE;
  logic [18:0] HALF_PERIOD;

  note_detector #(.TOL(TB_TOL), .TIMEOUT(TB_TMO), .NOM_SHIFT(TB_SHIFT)) dut (
    .CLK(CLK), .RESET(RESET), .TONE_IN(TONE_IN),
    .NOTE(NOTE), .NOTE_VALID(NOTE_VALID), .NOTE_CHANGE(NOTE_CHANGE),
    .HALF_PERIOD(HALF_PERIOD)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int chg_seen = 0;

  always @(negedge CLK) if (NOTE_CHANGE) chg_seen++;

  // Model: the lock depends only on the last two classified intervals since
  // the tone was (re)armed; a gap longer than TIMEOUT disarms it.
  bit m_idle, m_valid, m_chg, m_fresh;
  int m_prev, m_note, m_hp, m_chg_total = 0;

  typedef struct {
    bit rst;
    int gap;
    int note;
    bit valid;
    bit chg;
    int hp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input int g);
    int nom;
    for (int i = 0; i < 8; i++) begin
      nom = NOM_SPEC[i] >> TB_SHIFT;
      if (g >= nom - TB_TOL && g <= nom + TB_TOL) return i + 1;
    end
    return 0;
  endfunction

  task automatic model_edge(input int g);
    int c;
    m_hp = m_fresh ? g - 1 : g;
    if (m_hp > TB_TMO) m_hp = TB_TMO;
    m_fresh = 0;
    m_chg = 0;
    if (m_idle) begin
      m_idle = 0;
      m_prev = 0;
    end else begin
      c = cls_of(g);
      m_chg = (c != 0 && c == m_prev) && !m_valid;
      m_valid = (c != 0 && c == m_prev);
      m_note = m_valid ? c : 0;
      m_prev = c;
    end
    if (m_chg) m_chg_total++;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    TONE_IN = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    m_idle = 1; m_valid = 0; m_note = 0; m_prev = 0; m_hp = 0; m_fresh = 1;
    chk("rst_note", NOTE, 0);
    chk("rst_valid", NOTE_VALID, 0);
    chk("rst_change", NOTE_CHANGE, 0);
    chk("rst_hp", HALF_PERIOD, 0);
  endtask

  // Called three negedges after the previous toggle (or right after reset);
  // toggles the tone g cycles after the previous toggle and returns three
  // negedges later, when the outputs for that edge are first visible.
  task automatic apply_gap(input int g);
    int rest;
    rest = g - 3;
    if (!m_idle && g > TB_TMO) begin
      if (g >= TB_TMO + 10) begin
        repeat (TB_TMO - 1) @(negedge CLK);
        chk("pre_timeout_valid", NOTE_VALID, m_valid);
        chk("pre_timeout_note", NOTE, m_note);
        @(negedge CLK);
        chk("timeout_valid", NOTE_VALID, 0);
        chk("timeout_note", NOTE, 0);
        chk("timeout_hp_hold", HALF_PERIOD, m_hp);
        rest = g - 3 - TB_TMO;
      end
      m_idle = 1; m_valid = 0; m_note = 0; m_prev = 0;
    end
    repeat (rest) @(negedge CLK);
    TONE_IN = ~TONE_IN;
    model_edge(g);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    int idx, g, r;
    do_reset();

    // No tone for a long time: nothing may happen.
    repeat (3000) @(negedge CLK);
    chk("notone_note", NOTE, 0);
    chk("notone_valid", NOTE_VALID, 0);
    chk("notone_hp", HALF_PERIOD, 0);
    chk("notone_changes", chg_seen, 0);

    // Scaled nominals: C4 746 D 665 E 592 F 559 G 498 A 443 B 395 C5 373.
    tbl.push_back('{0, 443, 0, 0, 0, 442});  // arm (first edge after reset)
    tbl.push_back('{0, 443, 0, 0, 0, 443});  // candidate A
    tbl.push_back('{0, 443, 6, 1, 1, 443});  // lock A
    tbl.push_back('{0, 443, 6, 1, 0, 443});
    tbl.push_back('{0, 754, 0, 0, 0, 754});  // C4 + TOL: drop, candidate C4
    tbl.push_back('{0, 754, 1, 1, 1, 754});
    tbl.push_back('{0, 754, 1, 1, 0, 754});
    tbl.push_back('{0, 755, 0, 0, 0, 755});  // C4 + TOL + 1: no match
    tbl.push_back('{0, 755, 0, 0, 0, 755});
    tbl.push_back('{0, 738, 0, 0, 0, 738});  // C4 - TOL matches
    tbl.push_back('{0, 738, 1, 1, 1, 738});
    tbl.push_back('{0, 737, 0, 0, 0, 737});  // C4 - TOL - 1: no match
    tbl.push_back('{0, 746, 0, 0, 0, 746});
    tbl.push_back('{0, 746, 1, 1, 1, 746});  // locked C4
    tbl.push_back('{0, 373, 0, 0, 0, 373});  // switch to C5: drop
    tbl.push_back('{0, 373, 8, 1, 1, 373});  // relock C5
    tbl.push_back('{0, 373, 8, 1, 0, 373});
    tbl.push_back('{0, 592, 0, 0, 0, 592});  // E candidate
    tbl.push_back('{0, 559, 0, 0, 0, 559});  // F replaces candidate
    tbl.push_back('{0, 559, 4, 1, 1, 559});
    tbl.push_back('{0, 592, 0, 0, 0, 592});
    tbl.push_back('{0, 592, 3, 1, 1, 592});  // locked E
    tbl.push_back('{0, 2000, 0, 0, 0, 1023}); // tone stops: timeout, then arm
    tbl.push_back('{0, 498, 0, 0, 0, 498});
    tbl.push_back('{0, 1023, 0, 0, 0, 1023}); // edge coincides with timeout
    tbl.push_back('{0, 498, 0, 0, 0, 498});
    tbl.push_back('{0, 498, 5, 1, 1, 498});  // locked G
    tbl.push_back('{1, 498, 0, 0, 0, 497});  // reset mid-lock, re-arm
    tbl.push_back('{0, 498, 0, 0, 0, 498});
    tbl.push_back('{0, 498, 5, 1, 1, 498});

    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      apply_gap(tbl[i].gap);
      chk($sformatf("vec%0d_note", i), NOTE, tbl[i].note);
      chk($sformatf("vec%0d_valid", i), NOTE_VALID, tbl[i].valid);
      chk($sformatf("vec%0d_change", i), NOTE_CHANGE, tbl[i].chg);
      chk($sformatf("vec%0d_hp", i), HALF_PERIOD, tbl[i].hp);
    end

    // Random runs of notes with jitter around the window edges, stray
    // intervals and occasional dropouts.
    do_reset();
    idx = $urandom_range(0, 7);
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        g = 1100;
      end else if (r <= 2) begin
        g = $urandom_range(300, 800);
      end else begin
        if ($urandom_range(0, 3) == 0) idx = $urandom_range(0, 7);
        g = (NOM_SPEC[idx] >> TB_SHIFT) + int'($urandom_range(0, 2 * TB_TOL + 4)) - (TB_TOL + 2);
      end
      apply_gap(g);
      chk($sformatf("rnd%0d_note", n), NOTE, m_note);
      chk($sformatf("rnd%0d_valid", n), NOTE_VALID, m_valid);
      chk($sformatf("rnd%0d_change", n), NOTE_CHANGE, m_chg);
      chk($sformatf("rnd%0d_hp", n), HALF_PERIOD, m_hp);
    end

    repeat (5) @(negedge CLK);
    chk("change_pulse_total", chg_seen, m_chg_total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
